// File: rtl/inta_sequencer.sv
// Turns CPU INTA_n pulses into imp1/imp2 phase strobes for the priority resolver, gates INTR, drives data_oe.
// Pin-to-strobe latency is SYNC_STAGES+1 clocks on both edges; a stalled gap between INTA pulses aborts to IDLE.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic INTA_n,
  input  logic INT,
  input  logic endOfinit,
  input  logic SNGL,
  input  logic en,
  input  logic cas_match,
  output logic INTR,
  output logic imp1,
  output logic endOfimp1,
  output logic imp2,
  output logic endOfimp2,
  output logic data_oe,
  output logic ack_abort,
  output logic busy
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACK1 = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_ACK2 = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_inta_prev;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;

  logic w_inta_s;
  logic w_fall;
  logic w_rise;
  logic w_oe;
  logic w_timeout;
  logic w_can_start;

  assign w_inta_s  = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_inta_prev & ~w_inta_s;
  assign w_rise    = ~r_inta_prev & w_inta_s;
  assign w_oe      = SNGL | (~en & cas_match);
  // The counter is compared one step early so ack_abort lands on the cycle it reaches ACK_TIMEOUT.
  assign w_timeout = (r_cnt == CW'(ACK_TIMEOUT - 1));
  // A fall seen while endOfimp2 is still high belongs to the sequence just finished.
  assign w_can_start = w_fall & ~endOfimp2;
  assign busy      = (r_state != S_IDLE) && (r_state != S_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '1;
      r_inta_prev <= 1'b1;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], INTA_n};
      r_inta_prev <= w_inta_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      INTR      <= 1'b0;
      imp1      <= 1'b0;
      endOfimp1 <= 1'b0;
      imp2      <= 1'b0;
      endOfimp2 <= 1'b0;
      data_oe   <= 1'b0;
      ack_abort <= 1'b0;
    end else begin
      INTR      <= INT & endOfinit & ((r_state == S_IDLE) | (r_state == S_REQ));
      endOfimp1 <= 1'b0;
      endOfimp2 <= 1'b0;
      ack_abort <= 1'b0;
      case (r_state)
        S_IDLE, S_REQ: begin
          if (w_can_start) begin
            r_state <= S_ACK1;
            imp1    <= 1'b1;
          end else if ((r_state == S_IDLE) && INT && endOfinit) begin
            r_state <= S_REQ;
          end else if ((r_state == S_REQ) && !INT) begin
            r_state <= S_IDLE;
          end
        end
        S_ACK1: begin
          if (w_rise) begin
            imp1      <= 1'b0;
            endOfimp1 <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt != CW'(ACK_TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_fall) begin
            r_state <= S_ACK2;
            imp2    <= 1'b1;
            data_oe <= w_oe;
          end else if (w_timeout) begin
            ack_abort <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_ACK2: begin
          if (w_rise) begin
            imp2      <= 1'b0;
            data_oe   <= 1'b0;
            endOfimp2 <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            data_oe <= w_oe;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: stimulus tasks push expected phase events, a negedge monitor pops and compares them.
module tb_inta_sequencer;

  logic clk, rst, INTA_n, INT, endOfinit, SNGL, en, cas_match;
  logic INTR, imp1, endOfimp1, imp2, endOfimp2, data_oe, ack_abort, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_viol = 0;

  // Event word: {kind, length in cycles, data_oe cycles}; kind 1=end of imp1, 2=end of imp2, 3=abort.
  logic [23:0] exp_q[$];

  inta_sequencer #(.SYNC_STAGES(2), .ACK_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .INTA_n(INTA_n), .INT(INT), .endOfinit(endOfinit),
    .SNGL(SNGL), .en(en), .cas_match(cas_match), .INTR(INTR), .imp1(imp1),
    .endOfimp1(endOfimp1), .imp2(imp2), .endOfimp2(endOfimp2), .data_oe(data_oe),
    .ack_abort(ack_abort), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : monitor
    int c1, c2, coe, since;
    logic have;
    logic [23:0] got, want;
    c1 = 0; c2 = 0; coe = 0; since = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c1 = 0; c2 = 0; coe = 0;
      end else begin
        if (imp1 && imp2) n_viol++;
        if (endOfimp1 && imp2) n_viol++;
        if (data_oe && !imp2) n_viol++;
        if (imp1) c1++;
        if (imp2) c2++;
        if (imp2 && data_oe) coe++;
        since++;
        have = 1'b0;
        got  = '0;
        if (endOfimp1) begin
          since = 0;
          got = {8'd1, 8'(c1), 8'd0};
          c1 = 0;
          have = 1'b1;
        end
        if (endOfimp2) begin
          got = {8'd2, 8'(c2), 8'(coe)};
          c2 = 0; coe = 0;
          have = 1'b1;
        end
        if (ack_abort) begin
          got = {8'd3, 8'(since), 8'd0};
          have = 1'b1;
        end
        if (have) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected: got %h, required none at %0t", got, $time);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL event: got %h, required %h at %0t", got, want, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_inta(input int lo1, input int gap, input int lo2);
    INTA_n = 1'b0;
    tick(lo1);
    INTA_n = 1'b1;
    tick(gap);
    if (lo2 > 0) begin
      INTA_n = 1'b0;
      tick(lo2);
      INTA_n = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] outs;
    @(negedge clk);
    @(negedge clk);
    outs = {INTR, imp1, endOfimp1, imp2, endOfimp2, data_oe, ack_abort, busy};
    n_cmp++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000000", outs);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single;
    SNGL = 1'b1; en = 1'b1; INT = 1'b1; endOfinit = 1'b1;
    tick(4);
    n_cmp++;
    if (INTR !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_intr_req: got INTR=%b busy=%b, required 1 0", INTR, busy);
    end
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    exp_q.push_back({8'd2, 8'd5, 8'd5});
    INTA_n = 1'b0;
    tick(4);
    n_cmp++;
    if (imp1 !== 1'b1 || INTR !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack1: got imp1=%b INTR=%b busy=%b, required 1 0 1", imp1, INTR, busy);
    end
    tick(1);
    INTA_n = 1'b1;
    tick(3);
    INTA_n = 1'b0;
    tick(5);
    INTA_n = 1'b1;
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_no_init;
    int bad;
    bad = 0;
    endOfinit = 1'b0; INT = 1'b1;
    tick(2);
    repeat (100) begin
      tick(1);
      if (INTR !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_init: got %0d cycles with INTR/busy high, required 0", bad);
    end
    endOfinit = 1'b1;
    tick(3);
  endtask

  task automatic test_timeout;
    exp_q.push_back({8'd1, 8'd4, 8'd0});
    exp_q.push_back({8'd3, 8'd10, 8'd0});
    drive_inta(4, 0, 0);
    tick(25);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0 || imp2 !== 1'b0 || INTR !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_abort: got pending=%0d busy=%b imp2=%b INTR=%b, required 0 0 0 1",
               exp_q.size(), busy, imp2, INTR);
    end
    // A gap of exactly ACK_TIMEOUT cycles puts the fall on the timeout cycle; the fall must win.
    exp_q.push_back({8'd1, 8'd3, 8'd0});
    exp_q.push_back({8'd2, 8'd3, 8'd3});
    drive_inta(3, 10, 3);
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fall_wins: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_slave;
    SNGL = 1'b0; en = 1'b0; cas_match = 1'b0;
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    exp_q.push_back({8'd2, 8'd5, 8'd0});
    drive_inta(5, 3, 5);
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL slave_nomatch: got pending=%0d, required 0", exp_q.size());
    end
    cas_match = 1'b1;
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    exp_q.push_back({8'd2, 8'd5, 8'd5});
    drive_inta(5, 3, 5);
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL slave_match: got pending=%0d, required 0", exp_q.size());
    end
    SNGL = 1'b1; en = 1'b1; cas_match = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] outs;
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    drive_inta(5, 3, 0);
    INTA_n = 1'b0;
    tick(4);
    n_cmp++;
    if (imp2 !== 1'b1 || data_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ack2: got imp2=%b data_oe=%b, required 1 1", imp2, data_oe);
    end
    #2 rst = 1'b1;
    #1;
    outs = {INTR, imp1, endOfimp1, imp2, endOfimp2, data_oe, ack_abort, busy};
    n_cmp++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b, required 00000000", outs);
    end
    INTA_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    exp_q.push_back({8'd2, 8'd5, 8'd5});
    drive_inta(5, 3, 5);
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_req_drop;
    INT = 1'b1; endOfinit = 1'b1;
    tick(3);
    n_cmp++;
    if (INTR !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL req_hold: got INTR=%b busy=%b, required 1 0", INTR, busy);
    end
    INT = 1'b0;
    tick(1);
    n_cmp++;
    if (INTR !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop_intr: got INTR=%b, required 0", INTR);
    end
    tick(10);
    n_cmp++;
    if (busy !== 1'b0 || imp1 !== 1'b0 || INTR !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop_idle: got busy=%b imp1=%b INTR=%b, required 0 0 0", busy, imp1, INTR);
    end
    INT = 1'b1;
    tick(3);
  endtask

  task automatic test_back_to_back;
    exp_q.push_back({8'd1, 8'd5, 8'd0});
    exp_q.push_back({8'd2, 8'd5, 8'd5});
    exp_q.push_back({8'd1, 8'd4, 8'd0});
    exp_q.push_back({8'd2, 8'd6, 8'd6});
    drive_inta(5, 3, 5);
    tick(3);
    drive_inta(4, 3, 6);
    tick(8);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    n_cmp++;
    if (n_viol != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d overlapping cycles, required 0", n_viol);
    end
  endtask

  initial begin
    rst = 1'b1; INTA_n = 1'b1; INT = 1'b0; endOfinit = 1'b0;
    SNGL = 1'b1; en = 1'b1; cas_match = 1'b0;
    test_reset();
    test_single();
    test_no_init();
    test_timeout();
    test_slave();
    test_reset_mid();
    test_req_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
